// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder response checker.
//   chk_state_e : run-control state of the checker
//   chk_entry_t : one in-flight expected result {valid, idx, exp} at the
//                 default operand and counter widths
//   DEF_WIDTH   : default adder operand width
//   DEF_CNT_W   : default statistics counter width
package adder_chk_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  typedef struct packed {
    logic                 valid;
    logic [DEF_CNT_W-1:0] idx;
    logic [DEF_WIDTH:0]   exp;
  } chk_entry_t;

endpackage

// File: rtl/adder_chk_delay.sv
// LATENCY-deep shift register of expected-result entries.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, empties every stage
//   clr      : synchronous clear, empties every stage (new input dropped)
//   in_i     : entry written into stage 0 each cycle
//   stage_o  : all stage contents, stage_o[LATENCY-1] is the oldest
module adder_chk_delay
  import adder_chk_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter type         entry_t = chk_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  entry_t in_i,
  output entry_t stage_o [LATENCY]
);

  entry_t stage_d [LATENCY];
  entry_t stage_q [LATENCY];

  always_comb begin
    for (int unsigned k = 0; k < LATENCY; k++) begin
      stage_d[k] = '0;
    end
    if (!clr) begin
      stage_d[0] = in_i;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for the WIDTH-bit adder family (combinational and
// registered). Computes the golden A+B+C_IN for each accepted vector,
// delays it LATENCY cycles to line up with the DUT, compares against
// DUT_Q and keeps pass/fail statistics for a run of N_TESTS vectors.
//   CLK, RST_N      : clock (rising edge), async active-low reset
//   START           : one-cycle pulse, starts/restarts a run from any state
//   IN_VALID/READY  : stimulus handshake on A, B, C_IN
//   DUT_Q           : DUT result {carry, sum}
//   PASS_CNT/FAIL_CNT : saturating compare counters
//   ERR             : sticky mismatch flag for this run
//   FIRST_ERR_*     : index, expected and received value of first mismatch
//   DONE, PASS      : run complete, and complete without mismatch
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned N_TESTS = 10,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  input  logic [WIDTH:0]   DUT_Q,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic             ERR,
  output logic [CNT_W-1:0] FIRST_ERR_IDX,
  output logic [WIDTH:0]   FIRST_ERR_EXP,
  output logic [WIDTH:0]   FIRST_ERR_GOT,
  output logic             DONE,
  output logic             PASS
);

  localparam int unsigned      SUM_W      = WIDTH + 1;
  localparam logic [CNT_W-1:0] N_TESTS_C  = CNT_W'(N_TESTS);
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(N_TESTS - 1);

  // Same layout as chk_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] idx;
    logic [WIDTH:0]   exp;
  } entry_t;

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [WIDTH:0]   first_exp_q, first_exp_d;
  logic [WIDTH:0]   first_got_q, first_got_d;

  logic   accept;
  logic   any_valid;
  entry_t stage_in;
  entry_t stage [LATENCY];
  entry_t tail;

  assign IN_READY = (state_q == ST_RUN) && (issue_cnt_q < N_TESTS_C);
  assign accept   = IN_VALID && IN_READY;

  always_comb begin
    stage_in.valid = accept;
    stage_in.idx   = issue_cnt_q;
    stage_in.exp   = SUM_W'(A) + SUM_W'(B) + SUM_W'(C_IN);
  end

  // START empties the pipe, so a compare due on the START edge never counts.
  adder_chk_delay #(
    .LATENCY (LATENCY),
    .entry_t (entry_t)
  ) u_delay (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (START),
    .in_i    (stage_in),
    .stage_o (stage)
  );

  assign tail = stage[LATENCY-1];

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      any_valid = any_valid | stage[k].valid;
    end
  end

  // Run control. DRAIN ends once the compare of the last vector has left
  // the tail stage, i.e. LATENCY+1 edges after the last accept.
  always_comb begin
    state_d = state_q;
    if (START) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (accept && (issue_cnt_q == LAST_IDX_C)) state_d = ST_DRAIN;
        ST_DRAIN: if (!any_valid) state_d = ST_DONE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    err_d       = err_q;
    first_idx_d = first_idx_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    if (START) begin
      issue_cnt_d = '0;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      err_d       = 1'b0;
      first_idx_d = '0;
      first_exp_d = '0;
      first_got_d = '0;
    end else begin
      if (accept) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
      if (tail.valid) begin
        if (DUT_Q == tail.exp) begin
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end else begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          if (!err_q) begin
            err_d       = 1'b1;
            first_idx_d = tail.idx;
            first_exp_d = tail.exp;
            first_got_d = DUT_Q;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      err_q       <= 1'b0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      err_q       <= err_d;
      first_idx_q <= first_idx_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  // Decoded from state so that reset drops DONE/PASS asynchronously.
  assign DONE          = (state_q == ST_DONE);
  assign PASS          = DONE && !err_q;
  assign ERR           = err_q;
  assign PASS_CNT      = pass_cnt_q;
  assign FAIL_CNT      = fail_cnt_q;
  assign FIRST_ERR_IDX = first_idx_q;
  assign FIRST_ERR_EXP = first_exp_q;
  assign FIRST_ERR_GOT = first_got_q;

endmodule

// File: doc/adder_resp_checker.md
Name: adder_resp_checker

Overview:
- Synthesizable response checker for the 32-bit adder family, both combinational and registered variants.
- Takes the same A/B/C_IN stimulus that drives a DUT and computes the golden sum A+B+C_IN.
- Delays that sum to match the DUT pipeline latency, compares it with the DUT output, and keeps pass/fail statistics.
- It is the consuming end of the stimulus stream: instantiated next to a DUT in benches and on-board self-test wrappers.

Parameters:
- WIDTH, 32, operand width; the sum is WIDTH+1 bits.
- LATENCY, 1, clock cycles from the stimulus-sampling edge to the DUT_Q-valid edge; legal range 1..8; 1 matches the *_reg adders.
- N_TESTS, 10, number of vectors accepted per run.
- CNT_W, 16, width of the statistics counters.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  1-cycle pulse; begins or restarts a run.
- IN_VALID  input  1  stimulus on A/B/C_IN is valid this cycle.
- IN_READY  output  1  checker accepts stimulus this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C_IN  input  1  carry in.
- DUT_Q  input  WIDTH+1  DUT result {carry, sum}.
- PASS_CNT  output  CNT_W  number of matching compares.
- FAIL_CNT  output  CNT_W  number of mismatching compares.
- ERR  output  1  sticky: at least one mismatch this run.
- FIRST_ERR_IDX  output  CNT_W  vector index (0-based) of the first mismatch.
- FIRST_ERR_EXP  output  WIDTH+1  expected value at the first mismatch.
- FIRST_ERR_GOT  output  WIDTH+1  DUT_Q at the first mismatch.
- DONE  output  1  run complete; held until the next START.
- PASS  output  1  DONE && !ERR.

Behaviour:
- Reset: async assert on RST_N=0. All outputs 0, state IDLE, pipeline valids 0. Deassert is synchronous to CLK.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: START moves to RUN. START also clears the counters, ERR, the FIRST_ERR_* outputs, the issue count and the pipeline.
- IN_READY = (state==RUN) && (issue_cnt < N_TESTS).
- A vector is accepted when IN_VALID && IN_READY at a rising edge. IN_VALID while not ready is ignored.
- On accept:
  - stage[0] <= {valid=1, idx=issue_cnt, exp=A+B+C_IN}. The sum is zero-extended to WIDTH+1 bits and carry-out is kept.
  - issue_cnt increments.
- Non-accept cycles write valid=0 into stage[0].
- stage[k] <= stage[k-1] every cycle; the pipeline is LATENCY stages deep.
- Compare at every edge where stage[LATENCY-1].valid=1, against DUT_Q sampled at that edge.
  - Match: PASS_CNT+1.
  - Mismatch: FAIL_CNT+1. If ERR was 0, capture idx, exp and DUT_Q into FIRST_ERR_* and set ERR.
  - Counters saturate at all-ones.
- Timing example, LATENCY=1: vector accepted at edge t; the DUT registers at edge t; the compare happens at edge t+1.
- RUN -> DRAIN at the edge where the N_TESTS-th vector is accepted.
- DRAIN -> DONE at the first edge where no stage holds valid=1 and the compare for the last vector has been performed. DONE rises exactly LATENCY+1 edges after the last accept.
- DONE: DONE=1 and PASS=!ERR. Both hold until START.
- START in RUN or DRAIN aborts: pipeline cleared, stats cleared, state RUN. An in-flight compare coinciding with START is discarded.
- START in DONE restarts the same way.
- Reset mid-run discards everything. DONE and PASS drop immediately, asynchronously.
- A vector with IN_VALID gaps is compared in order. Gaps never produce compares.
- PASS_CNT+FAIL_CNT == N_TESTS at DONE, provided no saturation.

Decomposition:
- Shared package adder_chk_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the default WIDTH=32;
  - the pipeline entry struct {valid, idx, exp}.
- One sub-module, adder_chk_delay: a parameterised LATENCY-deep valid/data shift register with synchronous clear. The FSM, compare and statistics stay in the top level.

Test Plan:
- Reset, then START, then 10 vectors, including A=32'hFFFFFFFF, B=1, C_IN=1. The golden model is a correct registered adder. Expected: DONE at last accept + 2 edges, PASS_CNT=10, FAIL_CNT=0, PASS=1. The 33-bit compare must check carry-out 1 with sum 1.
- DUT_Q forced wrong on vector index 3 only, with exp 35 and got 34. Expected: FAIL_CNT=1, PASS_CNT=9, ERR=1, FIRST_ERR_IDX=3, FIRST_ERR_EXP=35, FIRST_ERR_GOT=34, PASS=0.
- IN_VALID toggled 1-0-0-1 with gaps, and 12 vectors offered. Expected: only 10 accepted, IN_READY=0 after the 10th, compares happen only for valid vectors, count=10.
- LATENCY=3 with a 3-stage DUT. Expected: all match. The same bench with LATENCY=1 must report failures.
- START pulsed mid-run after 4 accepts. Expected: stats reset to 0, the run restarts, and the final PASS_CNT=10. Then RST_N low for 1 cycle in DRAIN: DONE=0 immediately, state IDLE, START required again.
